// File: rtl/fifo_pkg.sv
// Shared pointer types and Gray/binary conversions for the dual-clock FIFO.
package fifo_pkg;

  localparam int unsigned PTR_W_DEFAULT = 8;

  // Conversions operate on a wide container so any pointer width up to
  // PTR_W_MAX can use them; callers zero-extend in and truncate out.
  localparam int unsigned PTR_W_MAX = 32;

  typedef logic [PTR_W_DEFAULT-1:0] ptr_t;
  typedef logic [PTR_W_MAX-1:0]     ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits pass through the prefix-XOR unchanged, so the result
  // is correct for any narrower pointer that was zero-extended.
  function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
    ptr_wide_t bin;
    bin = '0;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int unsigned i = 1; i < PTR_W_MAX; i++) begin
      bin[PTR_W_MAX-1-i] = bin[PTR_W_MAX-i] ^ gray[PTR_W_MAX-1-i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into CLK.
module ptr_sync_2ff #(
  parameter int unsigned WIDTH = fifo_pkg::PTR_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] PTR_IN,
  output logic [WIDTH-1:0] PTR_OUT
);

  logic [WIDTH-1:0] meta_q;

  // First stage may go metastable; second stage presents a settled value.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta_q  <= '0;
      PTR_OUT <= '0;
    end else begin
      meta_q  <= PTR_IN;
      PTR_OUT <= meta_q;
    end
  end

endmodule

// File: rtl/empty_flag_logic.sv
// Read-side pointer and flag controller for the dual-clock FIFO.
module empty_flag_logic
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = PTR_W_DEFAULT,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             READ_ENA,
  input  logic [WIDTH-1:0] WRITE_PTR,
  output logic [WIDTH-1:0] READ_PTR,
  output logic [WIDTH-2:0] READ_ADDR,
  output logic             EMPTY,
  output logic             ALMOST_EMPTY,
  output logic             READ_VALID,
  output logic             UNDERFLOW
);

  logic [WIDTH-1:0] rbin_q;
  logic [WIDTH-1:0] wsync;
  logic             rd_acc;
  logic [WIDTH-1:0] rbin_next;
  logic [WIDTH-1:0] rgray_next;
  logic [WIDTH-1:0] wsync_bin;
  logic [WIDTH-1:0] level;
  logic             empty_next;
  logic             ae_next;

  ptr_sync_2ff #(
    .WIDTH (WIDTH)
  ) u_wptr_sync (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .PTR_IN  (WRITE_PTR),
    .PTR_OUT (wsync)
  );

  // Next pointer and flag values; the compare uses the post-read pointer so
  // the last read of a burst raises EMPTY on the same edge.
  always_comb begin
    rd_acc     = READ_ENA & ~EMPTY;
    rbin_next  = rbin_q + {{(WIDTH-1){1'b0}}, rd_acc};
    rgray_next = WIDTH'(bin2gray(ptr_wide_t'(rbin_next)));
    wsync_bin  = WIDTH'(gray2bin(ptr_wide_t'(wsync)));
    // WIDTH-bit modular difference keeps a completely full FIFO distinct from 0
    level      = wsync_bin - rbin_next;
    empty_next = (rgray_next == wsync);
    ae_next    = (level <= WIDTH'(AE_THRESH));
  end

  // Pointer, address and flag registers; reset overrides any pending read.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rbin_q       <= '0;
      READ_PTR     <= '0;
      READ_ADDR    <= '0;
      EMPTY        <= 1'b1;
      ALMOST_EMPTY <= 1'b1;
      READ_VALID   <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      rbin_q       <= rbin_next;
      READ_PTR     <= rgray_next;
      READ_ADDR    <= rbin_next[WIDTH-2:0];
      EMPTY        <= empty_next;
      ALMOST_EMPTY <= ae_next;
      READ_VALID   <= rd_acc;
      UNDERFLOW    <= UNDERFLOW | (READ_ENA & EMPTY);
    end
  end

endmodule

// File: tb/tb_empty_flag_logic.sv
// Self-checking bench for empty_flag_logic (WIDTH=4, depth 8, AE_THRESH=2).
module tb_empty_flag_logic;

  localparam int W  = 4;
  localparam int AE = 2;

  logic         CLK;
  logic         RST_N;
  logic         READ_ENA;
  logic [W-1:0] WRITE_PTR;
  logic [W-1:0] READ_PTR;
  logic [W-2:0] READ_ADDR;
  logic         EMPTY;
  logic         ALMOST_EMPTY;
  logic         READ_VALID;
  logic         UNDERFLOW;

  empty_flag_logic #(
    .WIDTH     (W),
    .AE_THRESH (AE)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .READ_ENA     (READ_ENA),
    .WRITE_PTR    (WRITE_PTR),
    .READ_PTR     (READ_PTR),
    .READ_ADDR    (READ_ADDR),
    .EMPTY        (EMPTY),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .READ_VALID   (READ_VALID),
    .UNDERFLOW    (UNDERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: unbounded entry counts, no pointer encodings.
  int wr_cnt = 0;   // entries written so far (drives WRITE_PTR)
  int m_rd   = 0;   // entries read so far
  int m_s1   = 0;   // write count one edge into the synchronizer
  int m_s2   = 0;   // write count visible to the read side
  bit m_e = 1, m_ae = 1, m_v = 0, m_u = 0;

  function automatic int gray_of(input int n);
    int b;
    b = n % 16;
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_update();
    bit acc;
    if (!RST_N) begin
      m_rd = 0; m_s1 = 0; m_s2 = 0;
      m_e = 1; m_ae = 1; m_v = 0; m_u = 0;
    end else begin
      acc = READ_ENA && !m_e;
      if (READ_ENA && m_e) m_u = 1;
      m_rd = m_rd + int'(acc);
      m_e  = (m_rd == m_s2);
      m_ae = ((m_s2 - m_rd) <= AE);
      m_v  = acc;
      m_s2 = m_s1;
      m_s1 = wr_cnt;
    end
  endtask

  task automatic cycle(input bit rst_n_i, input bit ren_i);
    RST_N     = rst_n_i;
    READ_ENA  = ren_i;
    WRITE_PTR = W'(gray_of(wr_cnt));
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_empty"}, int'(EMPTY),        int'(m_e));
    check({tag, "_ae"},    int'(ALMOST_EMPTY), int'(m_ae));
    check({tag, "_valid"}, int'(READ_VALID),   int'(m_v));
    check({tag, "_uflow"}, int'(UNDERFLOW),    int'(m_u));
    check({tag, "_rptr"},  int'(READ_PTR),     gray_of(m_rd));
    check({tag, "_raddr"}, int'(READ_ADDR),    m_rd % 8);
  endtask

  typedef struct {
    bit rst_n; bit ren; int wcnt;
    bit e; bit ae; bit v; bit u; int ptr; int addr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int valids;
    bit done;

    RST_N = 1'b0; READ_ENA = 1'b0; WRITE_PTR = '0;

    // Reset, write-latency, drain of 5 entries, then underflow.
    tbl[0]  = '{0,0,0, 1,1,0,0, 0,0};
    tbl[1]  = '{0,0,0, 1,1,0,0, 0,0};
    tbl[2]  = '{1,0,1, 1,1,0,0, 0,0};
    tbl[3]  = '{1,0,1, 1,1,0,0, 0,0};
    tbl[4]  = '{1,0,1, 0,1,0,0, 0,0};
    tbl[5]  = '{1,0,5, 0,1,0,0, 0,0};
    tbl[6]  = '{1,0,5, 0,1,0,0, 0,0};
    tbl[7]  = '{1,0,5, 0,0,0,0, 0,0};
    tbl[8]  = '{1,1,5, 0,0,1,0, 1,1};
    tbl[9]  = '{1,1,5, 0,0,1,0, 3,2};
    tbl[10] = '{1,1,5, 0,1,1,0, 2,3};
    tbl[11] = '{1,1,5, 0,1,1,0, 6,4};
    tbl[12] = '{1,1,5, 1,1,1,0, 7,5};
    tbl[13] = '{1,1,5, 1,1,0,1, 7,5};
    tbl[14] = '{1,0,5, 1,1,0,1, 7,5};

    @(negedge CLK);
    for (int i = 0; i < 15; i++) begin
      wr_cnt = tbl[i].wcnt;
      cycle(tbl[i].rst_n, tbl[i].ren);
      check($sformatf("vec%0d_empty", i), int'(EMPTY),        int'(tbl[i].e));
      check($sformatf("vec%0d_ae", i),    int'(ALMOST_EMPTY), int'(tbl[i].ae));
      check($sformatf("vec%0d_valid", i), int'(READ_VALID),   int'(tbl[i].v));
      check($sformatf("vec%0d_uflow", i), int'(UNDERFLOW),    int'(tbl[i].u));
      check($sformatf("vec%0d_rptr", i),  int'(READ_PTR),     tbl[i].ptr);
      check($sformatf("vec%0d_raddr", i), int'(READ_ADDR),    tbl[i].addr);
    end

    // Wrap: two rounds of fill-to-full then drain, 16 reads total.
    wr_cnt = 0;
    cycle(0, 0); cycle(0, 0);
    for (int r = 0; r < 2; r++) begin
      wr_cnt = wr_cnt + 8;
      for (int k = 0; k < 3; k++) begin
        cycle(1, 0);
        check_model("wrap_fill");
      end
      check("wrap_full_no_ae", int'(ALMOST_EMPTY), 0);
      valids = 0;
      done   = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        cycle(1, 1);
        check_model("wrap_drain");
        valids += int'(READ_VALID);
        if (EMPTY) done = 1;
      end
      check("wrap_drain_reached_empty", int'(done), 1);
      check("wrap_valid_count", valids, 8);
    end
    check("wrap_rptr_zero", int'(READ_PTR), 0);
    check("wrap_no_uflow", int'(UNDERFLOW), 0);

    // Reset in the middle of a burst at level 4.
    wr_cnt = 0;
    cycle(0, 0); cycle(0, 0);
    wr_cnt = 4;
    for (int k = 0; k < 3; k++) cycle(1, 0);
    check_model("mid_pre");
    cycle(1, 1);
    check("mid_burst_valid_before", int'(READ_VALID), 1);
    wr_cnt = 0;
    cycle(0, 1);
    check("mid_rst_valid", int'(READ_VALID), 0);
    check("mid_rst_empty", int'(EMPTY), 1);
    check("mid_rst_addr",  int'(READ_ADDR), 0);
    check_model("mid_rst");

    // Randomized traffic against the reference model.
    cycle(0, 0);
    for (int n = 0; n < 400; n++) begin
      bit rst_b;
      rst_b = ($urandom_range(0, 99) < 2);
      if (rst_b) wr_cnt = 0;
      else if ((wr_cnt - m_rd) < 8 && $urandom_range(0, 99) < 45) wr_cnt++;
      cycle(!rst_b, 1'($urandom_range(0, 1)));
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
